// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREAD-port register file with per-register busy scoreboard.
// Optional same-cycle writeback bypass on reads when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  output logic                  any_busy
);
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr_en, iss_en;
  // Issue is applied after the write so a new producer wins over a same-cycle writeback.
  always_comb begin
    wr_en  = we && wa != '0;
    iss_en = issue_en && issue_addr != '0;
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[wa] = wd;
      busy_d[wa] = 1'b0;
    end
    if (iss_en) busy_d[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  assign any_busy = |busy_q[NREGS-1:1];
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a = rd_addr[g*AW +: AW];
`ifdef REGFILE_WRITE_BYPASS_EN
    assign hit = wr_en && a == wa;
`else
    assign hit = 1'b0;
`endif
    // Outputs are forced quiet while reset is held so a bypassed write cannot leak through.
    assign rd_data[g*XLEN +: XLEN] = !reset ? '0 : hit ? wd : regs_q[a];
    assign rd_busy[g] = reset && ((hit && !(iss_en && issue_addr == wa)) ? 1'b0 : busy_q[a]);
  end
endmodule
